// File: rtl/hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: validates the trigger width, waits the burst delay,
// then drives echo high for a width proportional to the programmed distance.
module hcsr04_emulador #(
  parameter int unsigned TRIGGER_MIN     = 500,
  parameter int unsigned ATRASO_ECHO     = 10000,
  parameter int unsigned CICLOS_POR_CM   = 2941,
  parameter int unsigned DIST_MAX        = 400,
  parameter int unsigned CICLOS_TIMEOUT  = 1900000,
  parameter int unsigned CICLOS_DESCANSO = 3000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic       erro_trigger,
  output logic [3:0] db_estado
);

  localparam logic [31:0] T_MIN   = 32'(TRIGGER_MIN);
  localparam logic [31:0] ATRASO_C = 32'(ATRASO_ECHO);
  localparam logic [31:0] CPC     = 32'(CICLOS_POR_CM);
  localparam logic [31:0] D_MAX   = 32'(DIST_MAX);
  localparam logic [31:0] T_OUT   = 32'(CICLOS_TIMEOUT);
  localparam logic [31:0] DESC    = 32'(CICLOS_DESCANSO);

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    MEDE_TRIGGER = 4'd1,
    ATRASO       = 4'd2,
    ECHO_ALTO    = 4'd3,
    DESCANSO     = 4'd4
  } estado_t;

  estado_t     estado, estado_prox;
  logic [31:0] conta, conta_prox, conta_inc;
  logic [31:0] n_ciclos, n_calc;
  logic        trigger_ant, borda;
  logic        echo_prox, erro_prox, latch;

  assign borda     = trigger & ~trigger_ant;
  assign conta_inc = (conta == '1) ? conta : conta + 32'd1;

  // Echo width is fixed at latch time; zero or out-of-range distances report a timeout.
  always_comb begin
    if (distancia == 9'd0 || 32'(distancia) > D_MAX) n_calc = T_OUT;
    else                                              n_calc = 32'(distancia) * CPC;
  end

  always_comb begin
    estado_prox = estado;
    echo_prox   = 1'b0;
    erro_prox   = 1'b0;
    latch       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (borda) estado_prox = MEDE_TRIGGER;
      end
      MEDE_TRIGGER: begin
        if (!trigger) begin
          if (conta >= T_MIN) begin
            estado_prox = ATRASO;
            latch       = 1'b1;
          end else begin
            estado_prox = OCIOSO;
            erro_prox   = 1'b1;
          end
        end
      end
      ATRASO: begin
        if (conta >= ATRASO_C) begin
          estado_prox = ECHO_ALTO;
          echo_prox   = 1'b1;
        end
      end
      ECHO_ALTO: begin
        // conta is 0 on the cycle echo rises, so the last high cycle sees n_ciclos-1.
        if (conta >= n_ciclos - 32'd1) estado_prox = DESCANSO;
        else                           echo_prox   = 1'b1;
      end
      DESCANSO: begin
        if (conta >= DESC - 32'd1) estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase

    // The entry edge into MEDE_TRIGGER already saw trigger high, hence the count starts at 1.
    if (estado_prox != estado) conta_prox = (estado_prox == MEDE_TRIGGER) ? 32'd1 : 32'd0;
    else if (estado == OCIOSO) conta_prox = conta;
    else                       conta_prox = conta_inc;
  end

  always_comb begin
    db_estado = 4'hF;
    case (estado)
      OCIOSO, MEDE_TRIGGER, ATRASO, ECHO_ALTO, DESCANSO: db_estado = estado;
      default: db_estado = 4'hF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      conta        <= 32'd0;
      trigger_ant  <= 1'b0;
      n_ciclos     <= 32'd0;
      echo         <= 1'b0;
      erro_trigger <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      estado       <= estado_prox;
      conta        <= conta_prox;
      trigger_ant  <= trigger;
      echo         <= echo_prox;
      erro_trigger <= erro_prox;
      ocupado      <= (estado_prox != OCIOSO);
      if (latch) n_ciclos <= n_calc;
    end
  end

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Bench for hcsr04_emulador: randomized trigger widths and distances checked against
// pulse-level timing rules (delay, echo width, holdoff) with scaled-down parameters.
module tb_hcsr04_emulador;

  localparam int TMIN = 6;
  localparam int ATR  = 20;
  localparam int CPC  = 3;
  localparam int DMAX = 40;
  localparam int TOUT = 150;
  localparam int DESC = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distancia = 9'd0;
  logic       echo, ocupado, erro_trigger;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  hcsr04_emulador #(
    .TRIGGER_MIN(TMIN), .ATRASO_ECHO(ATR), .CICLOS_POR_CM(CPC),
    .DIST_MAX(DMAX), .CICLOS_TIMEOUT(TOUT), .CICLOS_DESCANSO(DESC)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
    .echo(echo), .ocupado(ocupado), .erro_trigger(erro_trigger), .db_estado(db_estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference rule: echo width from the distance captured when the trigger is accepted.
  function automatic int largura(input int d);
    if (d == 0 || d > DMAX) return TOUT;
    return d * CPC;
  endfunction

  // modo 0: plain; 1: distance changes during the delay; 2: retrigger pulses during
  // echo and holdoff; 3: trigger held high across the end of the holdoff.
  task automatic medir(input int h, input int d, input int modo);
    int   cnt, w, dl;
    logic bad;
    distancia = 9'(d);
    trigger = 1'b1;
    tick();
    check("mede_state", 32'(db_estado), 32'd1);
    check("ocupado_rise", 32'(ocupado), 32'd1);
    repeat (h - 1) tick();
    trigger = 1'b0;
    tick();
    if (h < TMIN) begin
      check("erro_pulse", 32'(erro_trigger), 32'd1);
      check("reject_state", 32'(db_estado), 32'd0);
      tick();
      check("erro_one_cycle", 32'(erro_trigger), 32'd0);
      bad = 1'b0;
      repeat (ATR + 5) begin
        tick();
        if (echo || ocupado) bad = 1'b1;
      end
      check("reject_quiet", 32'(bad), 32'd0);
      return;
    end
    check("no_erro", 32'(erro_trigger), 32'd0);
    check("atraso_state", 32'(db_estado), 32'd2);
    cnt = 1;
    while (!echo && cnt < ATR + 50) begin
      tick();
      cnt++;
      if (modo == 1 && cnt == 3) distancia = 9'($urandom_range(0, 511));
    end
    check("echo_delay", 32'(cnt - 1), 32'(ATR + 1));
    if (!echo) return;
    check("echo_state", 32'(db_estado), 32'd3);
    w = 0;
    while (echo && w < TOUT + 50) begin
      tick();
      w++;
      if (modo == 2 && w == 2) trigger = 1'b1;
      if (modo == 2 && w == TMIN + 4) trigger = 1'b0;
    end
    check("echo_width", 32'(w), 32'(largura(d)));
    check("descanso_state", 32'(db_estado), 32'd4);
    dl = 0;
    bad = 1'b0;
    while (ocupado && dl < DESC + 50) begin
      tick();
      dl++;
      if (echo || erro_trigger) bad = 1'b1;
      if (modo == 2 && dl == 3) trigger = 1'b1;
      if (modo == 2 && dl == TMIN + 5) trigger = 1'b0;
      if (modo == 3 && dl == DESC - 5) trigger = 1'b1;
    end
    check("descanso_len", 32'(dl), 32'(DESC));
    check("descanso_quiet", 32'(bad), 32'd0);
    check("back_idle", 32'(db_estado), 32'd0);
    if (modo == 3) begin
      bad = 1'b0;
      repeat (2 * TMIN + ATR) begin
        tick();
        if (echo || ocupado || db_estado != 4'd0) bad = 1'b1;
      end
      check("held_trigger_ignored", 32'(bad), 32'd0);
      trigger = 1'b0;
      tick();
    end
  endtask

  initial begin
    int h, d, modo;
    #3;
    check("rst_echo", 32'(echo), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_erro", 32'(erro_trigger), 32'd0);
    check("rst_state", 32'(db_estado), 32'd0);
    #9 reset = 1'b1;
    tick();
    tick();

    medir(TMIN + 4, 5, 0);
    medir(TMIN - 1, 5, 0);
    medir(TMIN, 5, 0);
    medir(TMIN + 1, 0, 0);
    medir(TMIN + 1, DMAX + 10, 0);
    medir(TMIN + 1, DMAX, 0);
    medir(TMIN + 2, 5, 1);
    medir(TMIN + 2, 10, 2);
    medir(TMIN + 2, 7, 3);

    // Asynchronous reset in the middle of the echo pulse.
    distancia = 9'd30;
    trigger = 1'b1;
    repeat (TMIN + 2) tick();
    trigger = 1'b0;
    repeat (ATR + 10) tick();
    check("pre_reset_echo", 32'(echo), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_echo", 32'(echo), 32'd0);
    check("async_state", 32'(db_estado), 32'd0);
    check("async_ocupado", 32'(ocupado), 32'd0);
    #2 reset = 1'b1;
    tick();
    tick();
    medir(TMIN + 3, 12, 0);

    for (int i = 0; i < 20; i++) begin
      h    = $urandom_range(TMIN - 3, TMIN + 8);
      d    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(1, DMAX);
      modo = $urandom_range(0, 3);
      if (modo == 2 && d >= 1 && d <= 4) d = d + 4;
      medir(h, d, modo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hcsr04_emulador.md
Name: hcsr04_emulador

Overview:
Behavioural-synthesizable emulator of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol driven by interface_hcsr04. It accepts a trigger pulse, validates its width, waits the sensor burst delay, then drives echo high for a time proportional to a programmed distance in cm. It is used on the FPGA to close the loop for trena tests without the physical sensor, and as the sensor model in benches.

Parameters:
TRIGGER_MIN, 500, minimum trigger high width in cycles (10 us at 50 MHz)
ATRASO_ECHO, 10000, cycles from trigger fall to echo rise (200 us burst)
CICLOS_POR_CM, 2941, echo-high cycles per cm (58.82 us/cm at 50 MHz)
DIST_MAX, 400, largest valid distance in cm
CICLOS_TIMEOUT, 1900000, echo width for out-of-range distance (38 ms)
CICLOS_DESCANSO, 3000000, holdoff after echo falls before a new trigger is accepted (60 ms)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
trigger  input  1  trigger from the initiator, same clock domain, no synchronizer
distancia  input  9  emulated distance in cm, unsigned binary (0..511)
echo  output  1  echo pulse to the initiator
ocupado  output  1  high whenever not in OCIOSO
erro_trigger  output  1  one-cycle pulse on a rejected (short) trigger
db_estado  output  4  current state code for debug displays

Behaviour:
- Reset (reset=0): asynchronous; state=OCIOSO, echo=0, erro_trigger=0, ocupado=0, counter=0, trigger_ant=0, latched distance=0. echo drops immediately even mid-pulse.
- Registered trigger_ant is kept every cycle; rising edge = trigger & ~trigger_ant.
- One 32-bit cycle counter `conta`, cleared on every state change. Counting saturates at all-ones, never wraps.
- States and codes: OCIOSO=0, MEDE_TRIGGER=1, ATRASO=2, ECHO_ALTO=3, DESCANSO=4, all other codes=F. An illegal state returns to OCIOSO.
- OCIOSO: on rising edge go to MEDE_TRIGGER with conta=1. Trigger already high without an edge (held across DESCANSO) is ignored.
- MEDE_TRIGGER: while trigger=1, conta++. On the first edge that samples trigger=0:
  - If conta>=TRIGGER_MIN: latch distancia, go to ATRASO.
  - Otherwise: erro_trigger=1 for exactly that next cycle, go to OCIOSO.
  - Trigger held high forever: stay in MEDE_TRIGGER; no echo.
- ATRASO: after ATRASO_ECHO cycles in the state, go to ECHO_ALTO. echo rises ATRASO_ECHO+1 cycles after the edge that sampled trigger low.
- ECHO_ALTO: echo=1 for exactly N cycles, then echo=0 and go to DESCANSO.
  - N = dist_lat*CICLOS_POR_CM, computed once at latch time into a 32-bit register.
  - If dist_lat==0 or dist_lat>DIST_MAX, N=CICLOS_TIMEOUT.
- DESCANSO: CICLOS_DESCANSO cycles; all trigger activity is ignored, erro_trigger is never raised. Then go to OCIOSO.
- echo is a registered output, glitch-free. ocupado=(state!=OCIOSO), registered.
- distancia changes after latch have no effect until the next accepted trigger.

Test Plan:
- TRIGGER_MIN=500, distancia=5, 600-cycle trigger -> echo rises exactly 10001 cycles after trigger fall, stays high 14705 cycles, db_estado steps 0,1,2,3,4,0, ocupado high from trigger rise through end of DESCANSO.
- 499-cycle trigger -> erro_trigger pulses one cycle, echo stays 0, state 0. Then a 500-cycle trigger -> accepted.
- distancia=0 and distancia=450 (separate runs) -> echo width 1900000 cycles each. distancia=400 -> width 1176400.
- distancia changed 5→100 during ATRASO -> echo width still 14705.
- Retrigger pulse during ECHO_ALTO and during DESCANSO, plus trigger held high through end of DESCANSO -> ignored, no second echo until trigger falls and rises again.
- reset=0 asserted mid-ECHO_ALTO -> echo=0 at once, state 0. After release a full valid measurement completes normally. End-to-end: interface_hcsr04 driven against the emulator with distancia=123 -> medida reads 123 (±1).
